// File: rtl/sample_datapath.sv
// -----------------------------------------------------------------------------
// sample_datapath
//   Datapath partner of the six-state one-hot sequencer.
//   - S0 runs a prescaler. After DIVIDE consecutive S0 cycles it pulses OVERFLOW
//     to release the sequencer.
//   - S1..S5 loop: sample DIN, rectify it, accumulate with saturation, count
//     samples, then publish the running sum on DOUT.
//   - Clear shortcut (S2 -> S5): the accumulator, count and SAT are cleared
//     instead of publishing.
//
// Ports
//   CLK        in   rising-edge clock (shared with sequencer)
//   RESET_N    in   asynchronous active-low reset
//   S0..S5     in   registered one-hot strobes from the sequencer
//   CLR        in   informational copy of the sequencer CLR input (unused;
//                   the clear path is detected from the strobe order)
//   DIN        in   [DW-1:0] signed sample
//   OVERFLOW   out  registered one-cycle start pulse
//   DOUT       out  [AW-1:0] published accumulator value
//   DVALID     out  one-cycle pulse when DOUT updates
//   SAT        out  sticky saturation flag since last clear
//   NCNT       out  [7:0] samples accumulated since last clear (wraps)
//   ONEHOT_ERR out  sticky multi-hot strobe flag (only with ONEHOT_CHECK_EN)
//
// Optional build macro: ONEHOT_CHECK_EN adds the ONEHOT_ERR output and its
// check logic. Multi-hot cycles never update internal state in either build.
// -----------------------------------------------------------------------------
module sample_datapath #(
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int DIVIDE = 10,
  parameter int PW     = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          S0,
  input  logic          S1,
  input  logic          S2,
  input  logic          S3,
  input  logic          S4,
  input  logic          S5,
  input  logic          CLR,
  input  logic [DW-1:0] DIN,
  output logic          OVERFLOW,
  output logic [AW-1:0] DOUT,
  output logic          DVALID,
  output logic          SAT,
  output logic [7:0]    NCNT
`ifdef ONEHOT_CHECK_EN
  ,
  output logic          ONEHOT_ERR
`endif
);

  // Magnitude of a two's complement value as an unsigned DW-bit number.
  // The most negative value maps to 2^(DW-1), which still fits in DW bits.
  function automatic logic [DW-1:0] abs_mag(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    if (v[DW-1]) begin
      r = (~v) + DW'(1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

`ifdef ONEHOT_CHECK_EN
  // More than one strobe high: clearing the lowest set bit leaves something.
  function automatic logic multi_hot(input logic [5:0] v);
    return ((v & (v - 6'd1)) != 6'd0);
  endfunction
`endif

  logic [PW-1:0] pcnt_q,     pcnt_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] sample_q,   sample_d;
  logic [AW-1:0] operand_q,  operand_d;
  logic [AW-1:0] acc_q,      acc_d;
  logic [AW-1:0] dout_q,     dout_d;
  logic          dvalid_q,   dvalid_d;
  logic          sat_q,      sat_d;
  logic [7:0]    ncnt_q,     ncnt_d;
  logic          prev_s2_q,  prev_s2_d;
`ifdef ONEHOT_CHECK_EN
  logic          onehot_err_q, onehot_err_d;
`endif

  logic [5:0]    strb_s;
  logic [AW:0]   sum_s;
  logic          unused_clr_s;

  assign unused_clr_s = CLR;
  assign strb_s       = {S5, S4, S3, S2, S1, S0};

  // Next-state logic: decode the one-hot strobe and update the matching stage.
  always_comb begin
    pcnt_d     = pcnt_q;
    overflow_d = 1'b0;
    sample_d   = sample_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    sat_d      = sat_q;
    ncnt_d     = ncnt_q;
    prev_s2_d  = prev_s2_q;
    // One extra bit keeps the carry so saturation can be detected.
    sum_s      = {1'b0, acc_q} + {1'b0, operand_q};
`ifdef ONEHOT_CHECK_EN
    onehot_err_d = onehot_err_q | multi_hot(strb_s);
`endif

    case (strb_s)
      6'b000001: begin
        prev_s2_d = 1'b0;
        if (pcnt_q == PW'(DIVIDE - 1)) begin
          pcnt_d     = '0;
          overflow_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PW'(1'b1);
        end
      end
      6'b000010: begin
        pcnt_d    = '0;
        prev_s2_d = 1'b0;
        sample_d  = DIN;
      end
      6'b000100: begin
        pcnt_d    = '0;
        prev_s2_d = 1'b1;
        operand_d = AW'(abs_mag(sample_q));
      end
      6'b001000: begin
        pcnt_d    = '0;
        prev_s2_d = 1'b0;
        if (sum_s[AW]) begin
          acc_d = '1;
          sat_d = 1'b1;
        end else begin
          acc_d = sum_s[AW-1:0];
        end
      end
      6'b010000: begin
        pcnt_d    = '0;
        prev_s2_d = 1'b0;
        ncnt_d    = ncnt_q + 8'd1;
      end
      6'b100000: begin
        pcnt_d    = '0;
        prev_s2_d = 1'b0;
        // S5 straight after S2 is the clear shortcut; after S4 it publishes.
        if (prev_s2_q) begin
          acc_d  = '0;
          ncnt_d = 8'd0;
          sat_d  = 1'b0;
        end else begin
          dout_d   = acc_q;
          dvalid_d = 1'b1;
        end
      end
      default: begin
        // All low: sequencer in reset, prescaler restarts. Multi-hot: hold all.
        if (strb_s == 6'b000000) begin
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pcnt_q     <= '0;
      overflow_q <= 1'b0;
      sample_q   <= '0;
      operand_q  <= '0;
      acc_q      <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      sat_q      <= 1'b0;
      ncnt_q     <= 8'd0;
      prev_s2_q  <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      overflow_q <= overflow_d;
      sample_q   <= sample_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      sat_q      <= sat_d;
      ncnt_q     <= ncnt_d;
      prev_s2_q  <= prev_s2_d;
    end
  end

`ifdef ONEHOT_CHECK_EN
  // Sticky multi-hot flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      onehot_err_q <= 1'b0;
    end else begin
      onehot_err_q <= onehot_err_d;
    end
  end

  assign ONEHOT_ERR = onehot_err_q;
`endif

  assign OVERFLOW = overflow_q;
  assign DOUT     = dout_q;
  assign DVALID   = dvalid_q;
  assign SAT      = sat_q;
  assign NCNT     = ncnt_q;

endmodule
